// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front-end with a 2-entry {instr,pc} queue and redirect flush.
// Define IFETCH_HALT_EN to stop fetching after a 16'h0000 word is enqueued.
module ifetch_queue #(
   parameter logic [9:0] RESET_PC = 10'h000
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic [9:0]  IMEM_ADDR,
   input  logic [15:0] IMEM_Q,
   output logic [15:0] INSTR,
   output logic [9:0]  INSTR_PC,
   output logic        INSTR_VALID,
   input  logic        INSTR_READY,
   input  logic        REDIRECT,
   input  logic [9:0]  REDIRECT_PC,
   output logic        HALTED
);
   logic [9:0]  pc;
   logic [15:0] q_instr [2];
   logic [9:0]  q_pc [2];
   logic [1:0]  count, rem, n_count;
   logic        pop, push, halted;
   logic [15:0] n_instr0, n_instr1;
   logic [9:0]  n_pc0, n_pc1;

   assign IMEM_ADDR   = pc & 10'h3FE;
   assign INSTR_VALID = count != 2'd0;
   assign INSTR       = INSTR_VALID ? q_instr[0] : 16'h0000;
   assign INSTR_PC    = INSTR_VALID ? q_pc[0] : 10'h000;
   assign HALTED      = halted;

   // rem is the occupancy after the pop; a push lands in the first free slot behind it
   always_comb begin
      pop      = INSTR_VALID && INSTR_READY;
      push     = !REDIRECT && !halted && (count != 2'd2 || pop);
      rem      = count - {1'b0, pop};
      n_instr0 = (push && rem == 2'd0) ? IMEM_Q : (pop ? q_instr[1] : q_instr[0]);
      n_pc0    = (push && rem == 2'd0) ? IMEM_ADDR : (pop ? q_pc[1] : q_pc[0]);
      n_instr1 = (push && rem == 2'd1) ? IMEM_Q : q_instr[1];
      n_pc1    = (push && rem == 2'd1) ? IMEM_ADDR : q_pc[1];
      n_count  = rem + {1'b0, push};
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         count      <= 2'd0;
         pc         <= RESET_PC & 10'h3FE;
         q_instr[0] <= 16'h0000;
         q_instr[1] <= 16'h0000;
         q_pc[0]    <= 10'h000;
         q_pc[1]    <= 10'h000;
      end else if (REDIRECT) begin
         count <= 2'd0;
         pc    <= REDIRECT_PC & 10'h3FE;
      end else begin
         count      <= n_count;
         pc         <= push ? IMEM_ADDR + 10'd2 : pc;
         q_instr[0] <= n_instr0;
         q_instr[1] <= n_instr1;
         q_pc[0]    <= n_pc0;
         q_pc[1]    <= n_pc1;
      end
   end

`ifdef IFETCH_HALT_EN
   always_ff @(posedge CLK) begin
      if (!RESET || REDIRECT)
         halted <= 1'b0;
      else if (push && IMEM_Q == 16'h0000)
         halted <= 1'b1;
   end
`else
   assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed tests for ifetch_queue; RAM word at byte a is 16'h8000|(a>>1), except 16'h0000 at 0x038.
module tb_ifetch_queue;
   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [9:0]  IMEM_ADDR;
   logic [15:0] IMEM_Q;
   logic [15:0] INSTR;
   logic [9:0]  INSTR_PC;
   logic        INSTR_VALID;
   logic        INSTR_READY = 1'b0;
   logic        REDIRECT = 1'b0;
   logic [9:0]  REDIRECT_PC = 10'h000;
   logic        HALTED;
   int          passed = 0;
   int          total = 0;

   ifetch_queue dut (
      .CLK(CLK), .RESET(RESET), .IMEM_ADDR(IMEM_ADDR), .IMEM_Q(IMEM_Q),
      .INSTR(INSTR), .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID),
      .INSTR_READY(INSTR_READY), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
      .HALTED(HALTED)
   );

   always #5 CLK = ~CLK;

   assign IMEM_Q = (IMEM_ADDR == 10'h038) ? 16'h0000 : (16'h8000 | {7'd0, IMEM_ADDR[9:1]});

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RESET = 1'b0; INSTR_READY = 1'b1;
      tick; tick;
      total++; if (INSTR_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", INSTR_VALID); else passed++;
      total++; if (INSTR !== 16'h0000) $display("FAIL reset_instr got %h want 0000", INSTR); else passed++;
      total++; if (INSTR_PC !== 10'h000) $display("FAIL reset_pc got %h want 000", INSTR_PC); else passed++;
      total++; if (HALTED !== 1'b0) $display("FAIL reset_halted got %b want 0", HALTED); else passed++;
      total++; if (IMEM_ADDR !== 10'h000) $display("FAIL reset_addr got %h want 000", IMEM_ADDR); else passed++;
   endtask

   task automatic test_stream;
      RESET = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick;
         total++; if (INSTR_VALID !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", k, INSTR_VALID); else passed++;
         total++; if (INSTR_PC !== 10'(2 * k)) $display("FAIL stream_pc[%0d] got %h want %h", k, INSTR_PC, 10'(2 * k)); else passed++;
         total++; if (INSTR !== (16'h8000 | 16'(k))) $display("FAIL stream_instr[%0d] got %h want %h", k, INSTR, 16'h8000 | 16'(k)); else passed++;
         total++; if (IMEM_ADDR !== 10'(2 * k + 2)) $display("FAIL stream_addr[%0d] got %h want %h", k, IMEM_ADDR, 10'(2 * k + 2)); else passed++;
      end
   endtask

   task automatic test_backpressure;
      RESET = 1'b0; tick;
      RESET = 1'b1; INSTR_READY = 1'b0;
      tick;
      for (int k = 0; k < 4; k++) tick;
      total++; if (INSTR_PC !== 10'h000) $display("FAIL bp_head got %h want 000", INSTR_PC); else passed++;
      total++; if (IMEM_ADDR !== 10'h004) $display("FAIL bp_addr got %h want 004", IMEM_ADDR); else passed++;
      total++; if (INSTR_VALID !== 1'b1) $display("FAIL bp_valid got %b want 1", INSTR_VALID); else passed++;
      INSTR_READY = 1'b1;
      for (int k = 1; k < 4; k++) begin
         tick;
         total++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'(2 * k)) $display("FAIL bp_drain[%0d] got v=%b pc=%h want v=1 pc=%h", k, INSTR_VALID, INSTR_PC, 10'(2 * k)); else passed++;
      end
   endtask

   task automatic test_redirect;
      RESET = 1'b0; tick;
      RESET = 1'b1; INSTR_READY = 1'b0;
      tick; tick;
      REDIRECT = 1'b1; REDIRECT_PC = 10'h1F3;
      tick;
      REDIRECT = 1'b0;
      total++; if (INSTR_VALID !== 1'b0) $display("FAIL redir_bubble got %b want 0", INSTR_VALID); else passed++;
      total++; if (IMEM_ADDR !== 10'h1F2) $display("FAIL redir_addr got %h want 1f2", IMEM_ADDR); else passed++;
      tick;
      total++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h1F2) $display("FAIL redir_head got v=%b pc=%h want v=1 pc=1f2", INSTR_VALID, INSTR_PC); else passed++;
      total++; if (INSTR !== 16'h80F9) $display("FAIL redir_instr got %h want 80f9", INSTR); else passed++;
      INSTR_READY = 1'b1;
      tick;
      total++; if (INSTR_PC !== 10'h1F4) $display("FAIL redir_next got %h want 1f4", INSTR_PC); else passed++;
   endtask

   task automatic test_wrap;
      REDIRECT = 1'b1; REDIRECT_PC = 10'h3FE;
      tick;
      REDIRECT = 1'b0;
      tick;
      total++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h3FE) $display("FAIL wrap_top got v=%b pc=%h want v=1 pc=3fe", INSTR_VALID, INSTR_PC); else passed++;
      total++; if (INSTR !== 16'h81FF) $display("FAIL wrap_instr got %h want 81ff", INSTR); else passed++;
      tick;
      total++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h000) $display("FAIL wrap_zero got v=%b pc=%h want v=1 pc=000", INSTR_VALID, INSTR_PC); else passed++;
      total++; if (IMEM_ADDR !== 10'h002) $display("FAIL wrap_addr got %h want 002", IMEM_ADDR); else passed++;
   endtask

   task automatic test_reset_priority;
      INSTR_READY = 1'b0;
      tick; tick;
      RESET = 1'b0; REDIRECT = 1'b1; REDIRECT_PC = 10'h100; INSTR_READY = 1'b1;
      tick;
      total++; if (INSTR_VALID !== 1'b0) $display("FAIL rstpri_valid got %b want 0", INSTR_VALID); else passed++;
      total++; if (IMEM_ADDR !== 10'h000) $display("FAIL rstpri_addr got %h want 000", IMEM_ADDR); else passed++;
      RESET = 1'b1; REDIRECT = 1'b0;
      tick;
      total++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h000) $display("FAIL rstpri_first got v=%b pc=%h want v=1 pc=000", INSTR_VALID, INSTR_PC); else passed++;
   endtask

   task automatic test_halt;
      REDIRECT = 1'b1; REDIRECT_PC = 10'h034; INSTR_READY = 1'b1;
      tick;
      REDIRECT = 1'b0;
      tick; tick; tick;
      total++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h038 || INSTR !== 16'h0000) $display("FAIL halt_word got v=%b pc=%h i=%h want v=1 pc=038 i=0000", INSTR_VALID, INSTR_PC, INSTR); else passed++;
`ifdef IFETCH_HALT_EN
      total++; if (HALTED !== 1'b1) $display("FAIL halt_flag got %b want 1", HALTED); else passed++;
      tick; tick;
      total++; if (INSTR_VALID !== 1'b0) $display("FAIL halt_stop got %b want 0", INSTR_VALID); else passed++;
      total++; if (IMEM_ADDR !== 10'h03A) $display("FAIL halt_addr got %h want 03a", IMEM_ADDR); else passed++;
      REDIRECT = 1'b1; REDIRECT_PC = 10'h000;
      tick;
      REDIRECT = 1'b0;
      total++; if (HALTED !== 1'b0) $display("FAIL halt_clear got %b want 0", HALTED); else passed++;
      tick;
      total++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h000) $display("FAIL halt_resume got v=%b pc=%h want v=1 pc=000", INSTR_VALID, INSTR_PC); else passed++;
`else
      total++; if (HALTED !== 1'b0) $display("FAIL nohalt_flag got %b want 0", HALTED); else passed++;
      tick;
      total++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h03A || INSTR !== 16'h801D) $display("FAIL nohalt_next got v=%b pc=%h i=%h want v=1 pc=03a i=801d", INSTR_VALID, INSTR_PC, INSTR); else passed++;
      total++; if (IMEM_ADDR !== 10'h03C) $display("FAIL nohalt_addr got %h want 03c", IMEM_ADDR); else passed++;
`endif
   endtask

   initial begin
      test_reset;
      test_stream;
      test_backpressure;
      test_redirect;
      test_wrap;
      test_reset_priority;
      test_halt;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
